icache_dm_ctrl: RTL and testbench

- Parametrised direct-mapped instruction cache with a line-refill engine.
- Successor to the flat preloaded fetch memory. Keeps the same core-facing fetch handshake (icache_ack / icache_addr / icache_vld / icache_data).
- Adds tag/valid storage, a miss stall, burst refill from a backing-memory port, and a full invalidate (fence.i).
- Sits between the fetch stage and the memory/bus arbiter.

---
 rtl/icache_dm_ctrl_if.sv | 29 ++
 rtl/icache_dm_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_icache_dm_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/icache_dm_ctrl_if.sv
// Fetch-side and backing-memory-side signal bundle for icache_dm_ctrl.
// The cache sits on the slave modport; the core/arbiter side uses master.
interface icache_dm_ctrl_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  // core fetch handshake
  logic              icache_ack;
  logic [ADDR_W-1:0] icache_addr;
  logic              icache_vld;
  logic [DATA_W-1:0] icache_data;
  logic              icache_inv;
  // line refill port
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  icache_ack, icache_addr, icache_inv, mem_gnt, mem_rvalid, mem_rdata,
    output icache_vld, icache_data, mem_req, mem_addr
  );

  modport master (
    output icache_ack, icache_addr, icache_inv, mem_gnt, mem_rvalid, mem_rdata,
    input  icache_vld, icache_data, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_dm_ctrl.sv
// Direct-mapped instruction cache with a burst line-refill engine and a
// full invalidate. Lookup compares tag/valid in the accept cycle, so a hit
// returns its word one cycle later; a miss stalls the core (icache_vld=0)
// while the whole line is fetched in ascending offset order.
module icache_dm_ctrl #(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64,
  parameter int BYTE_SWAP  = 1
) (
  input  logic            sys_clk,
  input  logic            sys_set,
  icache_dm_ctrl_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_MISS_REQ,
    S_REFILL,
    S_RESP
  } state_e;

  // control state
  state_e            state_q,     state_d;
  logic [IDX_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [OFF_W-1:0]  beat_q,      beat_d;
  logic [OFF_W-1:0]  req_off_q,   req_off_d;
  logic              inv_pend_q,  inv_pend_d;
  logic              vld_q,       vld_d;
  logic [DATA_W-1:0] rdata_q,     rdata_d;
  logic              mem_req_q,   mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;

  // storage arrays
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q [SETS];
  logic [DATA_W-1:0] arr_q [SETS*LINE_WORDS];

  // array write controls
  logic              clr_en;
  logic              tag_we;
  logic              arr_we;

  // lookup of the presented fetch address
  logic [TAG_W-1:0]  lk_tag;
  logic [IDX_W-1:0]  lk_idx;
  logic [OFF_W-1:0]  lk_off;
  logic              lk_hit;
  logic [DATA_W-1:0] lk_word;

  // line being refilled comes from the registered request address
  logic [TAG_W-1:0]  rf_tag;
  logic [IDX_W-1:0]  rf_idx;
  logic [DATA_W-1:0] beat_word;

  assign lk_tag  = bus.icache_addr[ADDR_W-1 -: TAG_W];
  assign lk_idx  = bus.icache_addr[OFF_W +: IDX_W];
  assign lk_off  = bus.icache_addr[0 +: OFF_W];
  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_word = arr_q[{lk_idx, lk_off}];

  assign rf_tag  = mem_addr_q[ADDR_W-1 -: TAG_W];
  assign rf_idx  = mem_addr_q[OFF_W +: IDX_W];

  assign bus.icache_vld  = vld_q;
  assign bus.icache_data = rdata_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;

  // Optional byte reversal of each refill beat (big-endian image to LE core).
  always_comb begin
    beat_word = bus.mem_rdata;
    if (BYTE_SWAP != 0) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        beat_word[8*b +: 8] = bus.mem_rdata[DATA_W-8-8*b +: 8];
      end
    end
  end

  // Next-state and output logic for the lookup/refill/flush sequencer.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    beat_d      = beat_q;
    req_off_d   = req_off_q;
    inv_pend_d  = inv_pend_q;
    vld_d       = vld_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    clr_en      = 1'b0;
    tag_we      = 1'b0;
    arr_we      = 1'b0;

    case (state_q)
      S_FLUSH: begin
        clr_en = 1'b1;
        if (bus.icache_inv) begin
          flush_cnt_d = '0;
        end else if (flush_cnt_q == IDX_W'(SETS-1)) begin
          state_d = S_IDLE;
          vld_d   = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end

      // RESP already presents a valid word, so it accepts fetches like IDLE;
      // an invalidate that arrived during the refill takes priority here.
      S_IDLE, S_RESP: begin
        if (bus.icache_inv || inv_pend_q) begin
          state_d     = S_FLUSH;
          flush_cnt_d = '0;
          vld_d       = 1'b0;
          inv_pend_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
          if (bus.icache_ack && vld_q) begin
            if (lk_hit) begin
              rdata_d = lk_word;
            end else begin
              state_d    = S_MISS_REQ;
              vld_d      = 1'b0;
              mem_req_d  = 1'b1;
              mem_addr_d = {lk_tag, lk_idx, {OFF_W{1'b0}}};
              req_off_d  = lk_off;
              beat_d     = '0;
            end
          end
        end
      end

      S_MISS_REQ: begin
        if (bus.icache_inv) inv_pend_d = 1'b1;
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = S_REFILL;
        end
      end

      S_REFILL: begin
        if (bus.icache_inv) inv_pend_d = 1'b1;
        if (bus.mem_rvalid) begin
          arr_we = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == req_off_q) rdata_d = beat_word;
          if (beat_q == {OFF_W{1'b1}}) begin
            tag_we  = 1'b1;
            vld_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end

      default: begin
        state_d     = S_FLUSH;
        flush_cnt_d = '0;
        vld_d       = 1'b0;
      end
    endcase
  end

  // Control registers; reset abandons any refill and restarts the flush.
  always_ff @(posedge sys_clk) begin
    if (sys_set) begin
      state_q     <= S_FLUSH;
      flush_cnt_q <= '0;
      beat_q      <= '0;
      req_off_q   <= '0;
      inv_pend_q  <= 1'b0;
      vld_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      beat_q      <= beat_d;
      req_off_q   <= req_off_d;
      inv_pend_q  <= inv_pend_d;
      vld_q       <= vld_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  // Tag/valid/data arrays; valid bits are cleared only by the flush walk.
  always_ff @(posedge sys_clk) begin
    if (!sys_set) begin
      if (clr_en) valid_q[flush_cnt_q] <= 1'b0;
      if (tag_we) begin
        valid_q[rf_idx] <= 1'b1;
        tag_q[rf_idx]   <= rf_tag;
      end
      if (arr_we) arr_q[{rf_idx, beat_q}] <= beat_word;
    end
  end
endmodule

// File: tb/tb_icache_dm_ctrl.sv
// Bench for icache_dm_ctrl: two instances (raw and byte-swapped refill)
// share one stimulus stream; expected words come from a memory model and
// travel through a scoreboard queue from fetch issue to response.
module tb_icache_dm_ctrl;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int LW     = 4;
  localparam int SETS   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ack = 1'b0;
  logic              inv = 1'b0;
  logic              gnt = 1'b0;
  logic              rvalid = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] rdata = '0;

  int n_chk  = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] sb[$];

  icache_dm_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if0 ();
  icache_dm_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if1 ();

  assign if0.icache_ack = ack;    assign if1.icache_ack = ack;
  assign if0.icache_addr = addr;  assign if1.icache_addr = addr;
  assign if0.icache_inv = inv;    assign if1.icache_inv = inv;
  assign if0.mem_gnt = gnt;       assign if1.mem_gnt = gnt;
  assign if0.mem_rvalid = rvalid; assign if1.mem_rvalid = rvalid;
  assign if0.mem_rdata = rdata;   assign if1.mem_rdata = rdata;

  icache_dm_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LW),
                   .SETS(SETS), .BYTE_SWAP(0))
    u0 (.sys_clk(clk), .sys_set(rst), .bus(if0));
  icache_dm_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LW),
                   .SETS(SETS), .BYTE_SWAP(1))
    u1 (.sys_clk(clk), .sys_set(rst), .bus(if1));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // backing memory image: word = address + 0x90, one distinctive word at 0x30
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    if (a == ADDR_W'('h30)) return 32'h1122_3344;
    return DATA_W'(a) + 32'h90;
  endfunction

  function automatic logic [DATA_W-1:0] bswap(input logic [DATA_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_ctl(input string nm, input logic v, input logic r);
    chk({nm, ".vld0"}, 64'(if0.icache_vld), 64'(v));
    chk({nm, ".vld1"}, 64'(if1.icache_vld), 64'(v));
    chk({nm, ".req0"}, 64'(if0.mem_req), 64'(r));
    chk({nm, ".req1"}, 64'(if1.mem_req), 64'(r));
  endtask

  // stalls for SETS samples, then icache_vld returns; called at the first
  // negedge after the FLUSH state has been entered with counter 0
  task automatic flush_wait(input string nm);
    for (int i = 0; i < SETS; i++) begin
      chk_ctl({nm, ".flush"}, 1'b0, 1'b0);
      tick();
    end
    chk_ctl({nm, ".flush_done"}, 1'b1, 1'b0);
  endtask

  // one fetch; on a miss act as the memory: grant after gd cycles, then
  // LINE_WORDS consecutive beats, optionally pulsing inv with beat inv_beat
  task automatic fetch(input logic [ADDR_W-1:0] a, input bit hit, input int gd,
                       input int inv_beat);
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] e;
    base = a & ~ADDR_W'(LW-1);
    ack  = 1'b1;
    addr = a;
    sb.push_back(mem_word(a));
    tick();
    ack = 1'b0;
    if (!hit) begin
      chk_ctl("miss", 1'b0, 1'b1);
      chk("mem_addr", 64'(if0.mem_addr), 64'(base));
      repeat (gd) begin
        tick();
        chk_ctl("req_hold", 1'b0, 1'b1);
      end
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
      chk_ctl("granted", 1'b0, 1'b0);
      for (int b = 0; b < LW; b++) begin
        rvalid = 1'b1;
        rdata  = mem_word(base + ADDR_W'(b));
        inv    = (b == inv_beat);
        tick();
        rvalid = 1'b0;
        inv    = 1'b0;
        if (b < LW-1) chk_ctl("refill", 1'b0, 1'b0);
      end
    end
    chk_ctl(hit ? "hit" : "resp", 1'b1, 1'b0);
    e = sb.pop_front();
    chk("data", 64'(if0.icache_data), 64'(e));
    chk("data_swap", 64'(if1.icache_data), 64'(bswap(e)));
  endtask

  typedef struct {
    logic [ADDR_W-1:0] a;
    bit                hit;
    int                gd;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // index = addr[3:2], tag = addr[29:4] for LW=4, SETS=4
    tbl[0]  = '{ADDR_W'('h10), 1'b0, 2};  // cold miss, late grant
    tbl[1]  = '{ADDR_W'('h11), 1'b1, 0};
    tbl[2]  = '{ADDR_W'('h13), 1'b1, 0};
    tbl[3]  = '{ADDR_W'('h12), 1'b1, 0};
    tbl[4]  = '{ADDR_W'('h20), 1'b0, 0};  // same index, other tag
    tbl[5]  = '{ADDR_W'('h10), 1'b0, 1};  // evicted above
    tbl[6]  = '{ADDR_W'('h15), 1'b0, 0};  // mid-line offset
    tbl[7]  = '{ADDR_W'('h17), 1'b1, 0};
    tbl[8]  = '{ADDR_W'('h30), 1'b0, 1};  // 0x11223344 beat
    tbl[9]  = '{ADDR_W'('h14), 1'b1, 0};
    tbl[10] = '{ADDR_W'('h13), 1'b0, 0};  // last-offset capture

    @(negedge clk);
    rst = 1'b1;
    repeat (2) tick();
    chk_ctl("reset", 1'b0, 1'b0);
    chk("reset.data", 64'(if0.icache_data), 64'h0);
    chk("reset.addr", 64'(if0.mem_addr), 64'h0);
    rst = 1'b0;
    flush_wait("reset");
    chk("post_reset.data", 64'(if0.icache_data), 64'h0);

    for (int i = 0; i < 11; i++) fetch(tbl[i].a, tbl[i].hit, tbl[i].gd, -1);

    // invalidate during beat 2: word still returned, then full flush
    fetch(ADDR_W'('h25), 1'b0, 1, 2);
    tick();
    flush_wait("inv_refill");
    fetch(ADDR_W'('h25), 1'b0, 0, -1);
    fetch(ADDR_W'('h26), 1'b1, 0, -1);

    // inv together with ack in IDLE: fetch dropped, data held
    ack  = 1'b1;
    addr = ADDR_W'('h26);
    inv  = 1'b1;
    tick();
    ack = 1'b0;
    inv = 1'b0;
    flush_wait("inv_ack");
    chk("inv_ack.data_held", 64'(if0.icache_data), 64'(mem_word(ADDR_W'('h26))));
    fetch(ADDR_W'('h26), 1'b0, 0, -1);

    // inv during FLUSH restarts the walk
    inv = 1'b1;
    tick();
    inv = 1'b0;
    tick();
    inv = 1'b1;
    tick();
    inv = 1'b0;
    flush_wait("restart");
    fetch(ADDR_W'('h26), 1'b0, 0, -1);

    // reset mid-refill with stray beats afterwards
    ack  = 1'b1;
    addr = ADDR_W'('h11);
    tick();
    ack = 1'b0;
    chk_ctl("rst_refill.miss", 1'b0, 1'b1);
    gnt = 1'b1;
    tick();
    gnt    = 1'b0;
    rvalid = 1'b1;
    rdata  = mem_word(ADDR_W'('h10));
    tick();
    rdata = mem_word(ADDR_W'('h11));
    tick();
    rst   = 1'b1;
    rdata = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0;
    chk("rst_refill.data", 64'(if0.icache_data), 64'h0);
    flush_wait("rst_refill");
    tick();
    rvalid = 1'b0;
    chk_ctl("stray_idle", 1'b1, 1'b0);
    fetch(ADDR_W'('h11), 1'b0, 1, -1);
    fetch(ADDR_W'('h12), 1'b1, 0, -1);

    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
